// File: rtl/div16_16cycle_pkg.sv
// Shared definitions for the 16-cycle restoring divider.
//   DIV_WIDTH : operand, quotient and remainder width (one quotient bit per clock)
//   CNT_W     : width of the iteration counter
//   state_e   : divider FSM states
package div_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/div16_16cycle_if.sv
// Request/result bundle for div16_16cycle.
// Handshake: the master raises start with dividend/divisor for one or more
// cycles; the divider takes it only on an edge where it is IDLE (busy=0 and
// done=0). busy is high while iterating; done pulses for exactly one cycle
// when quotient/remainder become valid, and they hold until the next accepted
// start.
//   start, dividend, divisor           : master -> divider
//   busy, done, quotient, remainder    : divider -> master
//   dbz (only with DIV_BY_ZERO_FLAG_EN): divider -> master, sticky div-by-zero
interface div16_16cycle_if;
  import div_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic                 dbz;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, dbz);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, dbz);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder);
`endif
endinterface

// File: rtl/div16_16cycle_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder, trial-subtracts the
// divisor, and keeps the difference only if it did not go negative.
//   rem_i     : partial remainder (WIDTH+1 bits)
//   bit_i     : next dividend bit (MSB of the quotient/shift register)
//   divisor_i : divisor
//   rem_o     : updated partial remainder
//   q_bit_o   : resolved quotient bit
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // The partial remainder is always below the divisor, so rem_i[WIDTH] is 0
  // and the shifted value fits in WIDTH+1 bits. Carrying one extra bit keeps
  // the subtraction exact without relying on that invariant.
  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {2'b00, divisor_i};
  assign q_bit_o = ~trial[WIDTH+1];
  assign rem_o   = q_bit_o ? trial[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/div16_16cycle.sv
// div16_16cycle: sequential unsigned restoring divider, one quotient bit per
// clock, MSB first. Accepted start -> 16 RUN cycles -> one DONE cycle.
// Divide by zero needs no special path: every trial subtract succeeds, giving
// quotient = all ones and remainder = dividend.
// Optional macro DIV_BY_ZERO_FLAG_EN adds the sticky bus.dbz flag.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : request/result interface (slave side)
//   state_o : current FSM state, for observation
module div16_16cycle
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  div16_16cycle_if.slave      bus,
  output state_e              state_o
);
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] q_q, q_d;     // dividend shifts out, quotient shifts in
  logic [DIV_WIDTH:0]   rem_q, rem_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;

  logic [DIV_WIDTH:0]   step_rem;
  logic                 step_q_bit;

  div_step #(.WIDTH(DIV_WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (q_q[DIV_WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_d     = bus.dividend;
          dvs_d   = bus.divisor;
          rem_d   = '0;
          cnt_d   = CNT_W'(DIV_WIDTH - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        q_d   = {q_q[DIV_WIDTH-2:0], step_q_bit};
        rem_d = step_rem;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = q_q;
  assign bus.remainder = rem_q[DIV_WIDTH-1:0];
  assign state_o       = state_q;

`ifdef DIV_BY_ZERO_FLAG_EN
  logic dbz_q;

  always_ff @(posedge clk) begin
    if (rst)                                dbz_q <= 1'b0;
    else if (state_q == IDLE && bus.start)  dbz_q <= (bus.divisor == '0);
  end

  assign bus.dbz = dbz_q;
`endif
endmodule
